// File: rtl/keypad_digit_entry_pkg.sv
// Shared definitions for the keypad digit entry path: debounce FSM state
// encodings and BCD digit constants.
package keypad_digit_entry_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  // True when the value is a legal decimal digit.
  function automatic logic is_bcd(input logic [BCD_W-1:0] v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/keypad_digit_entry_key_sync_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM. Emits a registered
// one-cycle accept together with the debounced key code, once per press.
module key_sync_debounce
  import keypad_digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [BCD_W-1:0] d,
  input  logic             all_off,
  input  logic             loadn,
  output logic             accept,
  output logic [BCD_W-1:0] key,
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [BCD_W-1:0] d_s1, s_d;
  logic             off_s1, s_off;

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [BCD_W-1:0] key_q, key_d;
  logic             accept_q, accept_d;

  // Bring the asynchronous encoder outputs into the clk domain; idle is "no key".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_s1   <= '0;
      s_d    <= '0;
      off_s1 <= 1'b1;
      s_off  <= 1'b1;
    end else begin
      d_s1   <= d;
      s_d    <= d_s1;
      off_s1 <= all_off;
      s_off  <= off_s1;
    end
  end

  // FSM, debounce counter, captured key and registered accept pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      accept_q <= accept_d;
    end
  end

  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state logic. Disabling entry parks the FSM in RELEASE_WAIT with an
  // empty count so a key already held must be fully released before it counts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    accept_d = 1'b0;
    if (loadn) begin
      state_d = ST_RELEASE_WAIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!s_off) begin
            state_d = ST_PRESS_WAIT;
            key_d   = s_d;
            cnt_d   = CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (s_off) begin
            state_d = ST_IDLE;
          end else if (s_d != key_q) begin
            key_d = s_d;
            cnt_d = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d  = ST_HELD;
              accept_d = 1'b1;
            end
          end
        end
        ST_HELD: begin
          // Key code changes while held are ignored: no roll-over entry.
          if (s_off) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!s_off) begin
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign accept    = accept_q;
  assign key       = key_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad digit entry: debounced key presses shift right-to-left into a
// four-digit BCD MM:SS cook-time register.
//
// Handshake: digit_valid is a one-cycle pulse with no ready; it is high in the
// first cycle the digit outputs show the newly shifted digit, and the consumer
// must take it in that cycle. key_state is a debug view of the debounce FSM.
module keypad_digit_entry
  import keypad_digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int MAX_DIGITS      = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       all_off,
  input  logic       loadn,
  input  logic       clearn,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       digit_valid,
  output logic       entry_full,
  output logic [1:0] key_state
);

  localparam int DIG_CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DIG_CNT_W-1:0] DIG_MAX = DIG_CNT_W'(MAX_DIGITS);

  logic             accept;
  logic [BCD_W-1:0] key;
  logic [DIG_CNT_W-1:0] count_q;
  logic             take;

  key_sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .resetn    (resetn),
    .d         (D),
    .all_off   (all_off),
    .loadn     (loadn),
    .accept    (accept),
    .key       (key),
    .state_dbg (key_state)
  );

  assign entry_full = (count_q == DIG_MAX);
  // Full entries and out-of-range codes are dropped without a pulse.
  assign take = accept && !entry_full && is_bcd(key);

  // Digit shift register and count; clear takes priority over a new digit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sec_ones    <= '0;
      sec_tens    <= '0;
      min_ones    <= '0;
      min_tens    <= '0;
      count_q     <= '0;
      digit_valid <= 1'b0;
    end else if (!clearn) begin
      sec_ones    <= '0;
      sec_tens    <= '0;
      min_ones    <= '0;
      min_tens    <= '0;
      count_q     <= '0;
      digit_valid <= 1'b0;
    end else if (take) begin
      min_tens    <= min_ones;
      min_ones    <= sec_tens;
      sec_tens    <= sec_ones;
      sec_ones    <= key;
      count_q     <= count_q + DIG_CNT_W'(1);
      digit_valid <= 1'b1;
    end else begin
      digit_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry with DEBOUNCE_CYCLES=4. Expected
// digit snapshots are queued as each press is issued; a monitor pops one per
// digit_valid pulse.
module tb_keypad_digit_entry;
  import keypad_digit_entry_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] D = 4'd0;
  logic       all_off = 1'b1;
  logic       loadn = 1'b0;
  logic       clearn = 1'b1;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       digit_valid, entry_full;
  logic [1:0] key_state;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [15:0] exp_q[$];

  keypad_digit_entry #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (5),
    .MAX_DIGITS      (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .D           (D),
    .all_off     (all_off),
    .loadn       (loadn),
    .clearn      (clearn),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .min_tens    (min_tens),
    .digit_valid (digit_valid),
    .entry_full  (entry_full),
    .key_state   (key_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: act=timeout req=finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h", name, act, req);
    end
  endtask

  // Monitor: every digit_valid pulse must match the oldest expected snapshot.
  always @(negedge clk) begin
    if (digit_valid === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: act=%0h req=no_pulse", digits());
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (digits() !== e) begin
          errors++;
          $display("FAIL pulse_digits: act=%0h req=%0h", digits(), e);
        end
      end
    end
  end

  // Driver: clean press held for hold cycles, then released long enough to debounce.
  task automatic press(input logic [3:0] k, input int hold);
    @(negedge clk);
    D = k;
    all_off = 1'b0;
    repeat (hold) @(negedge clk);
    all_off = 1'b1;
    D = 4'd0;
    repeat (10) @(negedge clk);
  endtask

  task automatic clear_entry();
    @(negedge clk);
    clearn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
  endtask

  initial begin
    int lat;
    // Test 1: reset and idle.
    repeat (3) @(negedge clk);
    check("reset_digits", {16'd0, digits()}, 32'h0);
    check("reset_state", {30'd0, key_state}, {30'd0, ST_IDLE});
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_digits", {16'd0, digits()}, 32'h0);
    check("idle_full", {31'd0, entry_full}, 32'd0);
    check("idle_no_pulse", pulses, 0);

    // Test 2: clean press of 5 with latency measurement.
    exp_q.push_back(16'h0005);
    @(negedge clk);
    D = 4'd5;
    all_off = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (digit_valid === 1'b1 && lat == 0) lat = i;
    end
    check("press_latency", lat, 7);
    all_off = 1'b1;
    D = 4'd0;
    repeat (10) @(negedge clk);
    check("d5_digits", {16'd0, digits()}, 32'h0005);
    check("d5_pulses", pulses, 1);

    // Test 3: bouncing contact, then stable.
    exp_q.push_back(16'h0053);
    D = 4'd3;
    for (int i = 0; i < 12; i++) begin
      all_off = ((i / 2) % 2) == 1;
      @(negedge clk);
    end
    all_off = 1'b0;
    repeat (10) @(negedge clk);
    all_off = 1'b1;
    D = 4'd0;
    repeat (10) @(negedge clk);
    check("bounce_digits", {16'd0, digits()}, 32'h0053);
    check("bounce_pulses", pulses, 2);

    // Test 4: fill the entry, then an extra digit is refused.
    clear_entry();
    check("clear_digits", {16'd0, digits()}, 32'h0);
    exp_q.push_back(16'h0001); press(4'd1, 10);
    exp_q.push_back(16'h0012); press(4'd2, 10);
    exp_q.push_back(16'h0123); press(4'd3, 10);
    check("three_not_full", {31'd0, entry_full}, 32'd0);
    exp_q.push_back(16'h1230); press(4'd0, 10);
    check("full_flag", {31'd0, entry_full}, 32'd1);
    press(4'd7, 10);
    check("full_digits", {16'd0, digits()}, 32'h1230);
    check("full_still", {31'd0, entry_full}, 32'd1);
    check("full_pulses", pulses, 6);

    // Test 5: key held across loadn 1->0, then roll-over while held.
    clear_entry();
    @(negedge clk);
    loadn = 1'b1;
    repeat (2) @(negedge clk);
    check("loadn_state", {30'd0, key_state}, {30'd0, ST_RELEASE_WAIT});
    D = 4'd8;
    all_off = 1'b0;
    repeat (10) @(negedge clk);
    loadn = 1'b0;
    repeat (15) @(negedge clk);
    check("held_state", {30'd0, key_state}, {30'd0, ST_HELD});
    D = 4'd9;
    repeat (5) @(negedge clk);
    all_off = 1'b1;
    D = 4'd0;
    repeat (10) @(negedge clk);
    check("held_no_entry", {16'd0, digits()}, 32'h0);
    exp_q.push_back(16'h0008);
    @(negedge clk);
    D = 4'd8;
    all_off = 1'b0;
    repeat (10) @(negedge clk);
    D = 4'd9;
    repeat (8) @(negedge clk);
    all_off = 1'b1;
    D = 4'd0;
    repeat (10) @(negedge clk);
    check("repress_digits", {16'd0, digits()}, 32'h0008);
    check("repress_pulses", pulses, 7);

    // Test 6a: clear coincides with the accept edge; clear wins.
    @(negedge clk);
    D = 4'd4;
    all_off = 1'b0;
    repeat (6) @(negedge clk);
    clearn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
    check("clear_wins_digits", {16'd0, digits()}, 32'h0);
    check("clear_wins_valid", {31'd0, digit_valid}, 32'd0);
    repeat (4) @(negedge clk);
    all_off = 1'b1;
    D = 4'd0;
    repeat (10) @(negedge clk);
    check("clear_wins_pulses", pulses, 7);

    // Test 6b: asynchronous reset in the middle of a press.
    exp_q.push_back(16'h0002);
    press(4'd2, 10);
    @(negedge clk);
    D = 4'd6;
    all_off = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_press_state", {30'd0, key_state}, {30'd0, ST_PRESS_WAIT});
    resetn = 1'b0;
    #1;
    check("async_rst_digits", {16'd0, digits()}, 32'h0);
    check("async_rst_state", {30'd0, key_state}, {30'd0, ST_IDLE});
    check("async_rst_valid", {31'd0, digit_valid}, 32'd0);
    @(negedge clk);
    all_off = 1'b1;
    D = 4'd0;
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("final_pulses", pulses, 8);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
